// File: rtl/pa_risc_pkg.sv
// Shared PA_RISC pipeline constants: widths, reset PC, NOP encoding and the
// branch opcodes the control unit decodes.
package pa_risc_pkg;

    localparam int              ADDR_W   = 32;
    localparam int              INST_W   = 32;
    localparam logic [31:0]     RESET_PC = 32'h0000_0000;
    localparam logic [31:0]     NOP_INST = 32'h0000_0000;

    // Major opcodes (inst[31:26]) of the redirecting instructions.
    typedef enum logic [5:0] {
        OPC_COMBT = 6'h20,
        OPC_COMBF = 6'h22,
        OPC_BL    = 6'h3A
    } opcode_e;

    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/fetch_stage_if.sv
// IF-stage bus: hazard/branch controls in, imem port, IF/ID register and PCs out.
interface fetch_stage_if
    import pa_risc_pkg::*;
#(
    parameter int ADDR_W = pa_risc_pkg::ADDR_W,
    parameter int INST_W = pa_risc_pkg::INST_W
);
    logic              le;
    logic              branch_taken;
    logic [ADDR_W-1:0] branch_target;
    logic              nullify;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_data;
    logic [INST_W-1:0] if_id_inst;
    logic [ADDR_W-1:0] if_id_pc;
    logic [ADDR_W-1:0] pc_front;
    logic [ADDR_W-1:0] pc_back;
    logic              redirect_pending;

    modport master (
        input  le, branch_taken, branch_target, nullify, imem_data,
        output imem_addr, if_id_inst, if_id_pc, pc_front, pc_back, redirect_pending
    );

    modport slave (
        output le, branch_taken, branch_target, nullify, imem_data,
        input  imem_addr, if_id_inst, if_id_pc, pc_front, pc_back, redirect_pending
    );
endinterface

// File: rtl/pc_pair_reg.sv
// PC pair: pc_back is the address being fetched, pc_front the one after it.
// A load replaces the pair with {target, target+4}; otherwise the pair slides by 4.
module pc_pair_reg
    import pa_risc_pkg::*;
#(
    parameter int                ADDR_W   = pa_risc_pkg::ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = pa_risc_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_le,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_target,
    output logic [ADDR_W-1:0] o_pc_back,
    output logic [ADDR_W-1:0] o_pc_front
);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_INC);

    logic [ADDR_W-1:0] r_pc_back;
    logic [ADDR_W-1:0] r_pc_front;

    // Advance or redirect the pair when loading is enabled; additions wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_back  <= RESET_PC;
            r_pc_front <= RESET_PC + STEP;
        end else if (i_le) begin
            if (i_load) begin
                r_pc_back  <= i_target;
                r_pc_front <= i_target + STEP;
            end else begin
                r_pc_back  <= r_pc_front;
                r_pc_front <= r_pc_front + STEP;
            end
        end
    end

    assign o_pc_back  = r_pc_back;
    assign o_pc_front = r_pc_front;
endmodule

// File: rtl/fetch_stage.sv
// IF stage: drives imem from pc_back, loads the IF/ID register, and applies
// branch redirects with one delay slot. Redirects/nullifies seen during a
// stall are parked and take effect on the first cycle with le=1.
module fetch_stage
    import pa_risc_pkg::*;
#(
    parameter int                ADDR_W   = pa_risc_pkg::ADDR_W,
    parameter int                INST_W   = pa_risc_pkg::INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = pa_risc_pkg::RESET_PC
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);
    localparam logic [INST_W-1:0] NOP_W = INST_W'(NOP_INST);

    logic              r_redirect_pending;
    logic              r_pend_null;
    logic [ADDR_W-1:0] r_pend_target;
    logic [INST_W-1:0] r_if_id_inst;
    logic [ADDR_W-1:0] r_if_id_pc;

    logic              w_eff_br;
    logic              w_eff_null;
    logic [ADDR_W-1:0] w_eff_tgt;
    logic [ADDR_W-1:0] w_pc_back;
    logic [ADDR_W-1:0] w_pc_front;

    // A live branch_taken beats a parked one (newest request wins).
    always_comb begin
        w_eff_br   = bus.branch_taken | r_redirect_pending;
        w_eff_tgt  = bus.branch_taken ? bus.branch_target : r_pend_target;
        w_eff_null = bus.nullify | r_pend_null;
    end

    pc_pair_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_pair (
        .clk        (clk),
        .reset      (reset),
        .i_le       (bus.le),
        .i_load     (w_eff_br),
        .i_target   (w_eff_tgt),
        .o_pc_back  (w_pc_back),
        .o_pc_front (w_pc_front)
    );

    // IF/ID capture on le; while stalled, park any redirect/nullify request.
    // The parked nullify is consumed on the first unstalled cycle whether or
    // not a redirect accompanies it, so it cannot squash a later slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_if_id_inst       <= NOP_W;
            r_if_id_pc         <= '0;
            r_redirect_pending <= 1'b0;
            r_pend_null        <= 1'b0;
            r_pend_target      <= '0;
        end else if (bus.le) begin
            r_if_id_inst       <= w_eff_null ? NOP_W : bus.imem_data;
            r_if_id_pc         <= w_pc_back;
            r_redirect_pending <= 1'b0;
            r_pend_null        <= 1'b0;
        end else begin
            if (bus.branch_taken) begin
                r_pend_target      <= bus.branch_target;
                r_redirect_pending <= 1'b1;
            end
            if (bus.nullify) begin
                r_pend_null <= 1'b1;
            end
        end
    end

    assign bus.imem_addr        = w_pc_back;
    assign bus.pc_back          = w_pc_back;
    assign bus.pc_front         = w_pc_front;
    assign bus.if_id_inst       = r_if_id_inst;
    assign bus.if_id_pc         = r_if_id_pc;
    assign bus.redirect_pending = r_redirect_pending;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage. Snapshot vector per check:
// {pc_back, pc_front, if_id_inst, if_id_pc, redirect_pending}.
module tb_fetch_stage;
    import pa_risc_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic reset2;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fetch_stage_if #(.ADDR_W(32), .INST_W(32)) bus1 ();
    fetch_stage_if #(.ADDR_W(32), .INST_W(32)) bus2 ();

    assign bus1.imem_data = bus1.imem_addr | 32'hA000_0000;
    assign bus2.imem_data = bus2.imem_addr | 32'hA000_0000;

    fetch_stage #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    fetch_stage #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk   (clk),
        .reset (reset2),
        .bus   (bus2)
    );

    function automatic logic [128:0] snap1();
        return {bus1.pc_back, bus1.pc_front, bus1.if_id_inst, bus1.if_id_pc, bus1.redirect_pending};
    endfunction

    function automatic logic [128:0] snap2();
        return {bus2.pc_back, bus2.pc_front, bus2.if_id_inst, bus2.if_id_pc, bus2.redirect_pending};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [128:0] exp;
        reset = 1'b1;
        tick();
        tick();
        exp = {32'h0, 32'h4, 32'h0, 32'h0, 1'b0};
        n_tests++;
        if (snap1() !== exp) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", snap1(), exp);
        end
        n_tests++;
        if (bus1.imem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_imem_addr: got %h want %h", bus1.imem_addr, 32'h0);
        end
        reset = 1'b0;
        tick();
        exp = {32'h4, 32'h8, 32'hA000_0000, 32'h0, 1'b0};
        n_tests++;
        if (snap1() !== exp) begin
            n_fail++;
            $display("FAIL seq_fetch_1: got %h want %h", snap1(), exp);
        end
        tick();
        exp = {32'h8, 32'hC, 32'hA000_0004, 32'h4, 1'b0};
        n_tests++;
        if (snap1() !== exp) begin
            n_fail++;
            $display("FAIL seq_fetch_2: got %h want %h", snap1(), exp);
        end
        n_tests++;
        if (bus1.imem_addr !== 32'h8) begin
            n_fail++;
            $display("FAIL imem_addr_follows: got %h want %h", bus1.imem_addr, 32'h8);
        end
    endtask

    task automatic test_branch();
        logic [128:0] exp;
        bus1.branch_taken  = 1'b1;
        bus1.branch_target = 32'h40;
        tick();
        exp = {32'h40, 32'h44, 32'hA000_0008, 32'h8, 1'b0};
        n_tests++;
        if (snap1() !== exp) begin
            n_fail++;
            $display("FAIL branch_slot_kept: got %h want %h", snap1(), exp);
        end
        bus1.branch_target = 32'h60;
        bus1.nullify       = 1'b1;
        tick();
        exp = {32'h60, 32'h64, 32'h0, 32'h40, 1'b0};
        n_tests++;
        if (snap1() !== exp) begin
            n_fail++;
            $display("FAIL branch_slot_nullified: got %h want %h", snap1(), exp);
        end
        bus1.branch_taken = 1'b0;
        bus1.nullify      = 1'b0;
        tick();
        exp = {32'h64, 32'h68, 32'hA000_0060, 32'h60, 1'b0};
        n_tests++;
        if (snap1() !== exp) begin
            n_fail++;
            $display("FAIL first_fetch_at_target: got %h want %h", snap1(), exp);
        end
        bus1.nullify = 1'b1;
        tick();
        exp = {32'h68, 32'h6C, 32'h0, 32'h64, 1'b0};
        n_tests++;
        if (snap1() !== exp) begin
            n_fail++;
            $display("FAIL nullify_no_branch: got %h want %h", snap1(), exp);
        end
        bus1.nullify = 1'b0;
        tick();
        exp = {32'h6C, 32'h70, 32'hA000_0068, 32'h68, 1'b0};
        n_tests++;
        if (snap1() !== exp) begin
            n_fail++;
            $display("FAIL after_nullify: got %h want %h", snap1(), exp);
        end
    endtask

    task automatic test_stall_redirect();
        logic [128:0] exp;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        tick();
        exp = {32'hC, 32'h10, 32'hA000_0008, 32'h8, 1'b0};
        n_tests++;
        if (snap1() !== exp) begin
            n_fail++;
            $display("FAIL stall_setup: got %h want %h", snap1(), exp);
        end
        bus1.le = 1'b0;
        tick();
        n_tests++;
        if (snap1() !== exp) begin
            n_fail++;
            $display("FAIL stall_freeze_1: got %h want %h", snap1(), exp);
        end
        bus1.branch_taken  = 1'b1;
        bus1.branch_target = 32'h80;
        tick();
        exp = {32'hC, 32'h10, 32'hA000_0008, 32'h8, 1'b1};
        n_tests++;
        if (snap1() !== exp) begin
            n_fail++;
            $display("FAIL stall_pending_set: got %h want %h", snap1(), exp);
        end
        bus1.branch_taken  = 1'b0;
        bus1.branch_target = 32'h0;
        tick();
        n_tests++;
        if (snap1() !== exp) begin
            n_fail++;
            $display("FAIL stall_pending_held: got %h want %h", snap1(), exp);
        end
        bus1.le = 1'b1;
        tick();
        exp = {32'h80, 32'h84, 32'hA000_000C, 32'hC, 1'b0};
        n_tests++;
        if (snap1() !== exp) begin
            n_fail++;
            $display("FAIL stall_resume_redirect: got %h want %h", snap1(), exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [128:0] exp;
        bus1.le            = 1'b0;
        bus1.nullify       = 1'b1;
        bus1.branch_taken  = 1'b1;
        bus1.branch_target = 32'h100;
        tick();
        exp = {32'h80, 32'h84, 32'hA000_000C, 32'hC, 1'b1};
        n_tests++;
        if (snap1() !== exp) begin
            n_fail++;
            $display("FAIL b2b_first_pending: got %h want %h", snap1(), exp);
        end
        bus1.nullify       = 1'b0;
        bus1.branch_target = 32'h200;
        tick();
        n_tests++;
        if (snap1() !== exp) begin
            n_fail++;
            $display("FAIL b2b_second_pending: got %h want %h", snap1(), exp);
        end
        bus1.branch_taken  = 1'b0;
        bus1.branch_target = 32'h0;
        bus1.le            = 1'b1;
        tick();
        exp = {32'h200, 32'h204, 32'h0, 32'h80, 1'b0};
        n_tests++;
        if (snap1() !== exp) begin
            n_fail++;
            $display("FAIL b2b_newest_wins: got %h want %h", snap1(), exp);
        end
        tick();
        exp = {32'h204, 32'h208, 32'hA000_0200, 32'h200, 1'b0};
        n_tests++;
        if (snap1() !== exp) begin
            n_fail++;
            $display("FAIL b2b_pend_null_cleared: got %h want %h", snap1(), exp);
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [128:0] exp;
        bus1.le            = 1'b0;
        bus1.branch_taken  = 1'b1;
        bus1.branch_target = 32'h300;
        bus1.nullify       = 1'b1;
        tick();
        exp = {32'h204, 32'h208, 32'hA000_0200, 32'h200, 1'b1};
        n_tests++;
        if (snap1() !== exp) begin
            n_fail++;
            $display("FAIL rst_stall_pending: got %h want %h", snap1(), exp);
        end
        bus1.branch_taken  = 1'b0;
        bus1.branch_target = 32'h0;
        bus1.nullify       = 1'b0;
        reset              = 1'b1;
        tick();
        exp = {32'h0, 32'h4, 32'h0, 32'h0, 1'b0};
        n_tests++;
        if (snap1() !== exp) begin
            n_fail++;
            $display("FAIL rst_stall_cleared: got %h want %h", snap1(), exp);
        end
        reset   = 1'b0;
        bus1.le = 1'b1;
        tick();
        exp = {32'h4, 32'h8, 32'hA000_0000, 32'h0, 1'b0};
        n_tests++;
        if (snap1() !== exp) begin
            n_fail++;
            $display("FAIL rst_stall_no_stale: got %h want %h", snap1(), exp);
        end
    endtask

    task automatic test_wrap();
        logic [128:0] exp;
        reset2 = 1'b1;
        tick();
        tick();
        exp = {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0};
        n_tests++;
        if (snap2() !== exp) begin
            n_fail++;
            $display("FAIL wrap_reset: got %h want %h", snap2(), exp);
        end
        reset2 = 1'b0;
        tick();
        exp = {32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b0};
        n_tests++;
        if (snap2() !== exp) begin
            n_fail++;
            $display("FAIL wrap_step_1: got %h want %h", snap2(), exp);
        end
        tick();
        exp = {32'h0, 32'h4, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
        n_tests++;
        if (snap2() !== exp) begin
            n_fail++;
            $display("FAIL wrap_step_2: got %h want %h", snap2(), exp);
        end
        tick();
        exp = {32'h4, 32'h8, 32'hA000_0000, 32'h0, 1'b0};
        n_tests++;
        if (snap2() !== exp) begin
            n_fail++;
            $display("FAIL wrap_step_3: got %h want %h", snap2(), exp);
        end
    endtask

    initial begin
        reset              = 1'b1;
        reset2             = 1'b1;
        bus1.le            = 1'b1;
        bus1.branch_taken  = 1'b0;
        bus1.branch_target = 32'h0;
        bus1.nullify       = 1'b0;
        bus2.le            = 1'b1;
        bus2.branch_taken  = 1'b0;
        bus2.branch_target = 32'h0;
        bus2.nullify       = 1'b0;

        test_reset();
        test_branch();
        test_stall_redirect();
        test_back_to_back();
        test_reset_mid_stall();
        test_wrap();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
